sti_dac_param: RTL and testbench

//  Parametrised successor serial-transmit / pixel-DAC front end. Takes parallel words on a load

---
 rtl/sti_dac_pkg.sv | 8 +
 rtl/sti_pixel_packer.sv | 50 +++++
 rtl/sti_dac_param.sv | 80 ++++++++
 tb/tb_sti_dac_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared FSM states, pi_length codes and serial length lookup for sti_dac_param
package sti_dac_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FILL, DONE} state_t;
  localparam logic [1:0] LEN_BYTE = 2'b00, LEN_WORD = 2'b01, LEN_3BYTE = 2'b10, LEN_4BYTE = 2'b11;
  function automatic int len_bits(input logic [1:0] len, input int byte_w);
    return (int'(len) + 1) * byte_w;
  endfunction
endpackage

// File: rtl/sti_pixel_packer.sv
// sti_pixel_packer: packs the serial bit stream into pixels, flushes a partial pixel and zero-fills memory
module sti_pixel_packer #(
  parameter int PIX_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              fill,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout,
  output logic              fill_last
);
  localparam int CW = $clog2(PIX_W + 1);
  localparam logic [CW-1:0] PW = CW'(PIX_W);
  logic [PIX_W-1:0] acc, shifted;
  logic [CW-1:0] pcnt;
  always_comb begin
    shifted = {acc[PIX_W-2:0], bit_in};
    fill_last = pixel_wr && &pixel_addr;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pixel_wr <= 1'b0;
      pixel_addr <= '0;
      pixel_dataout <= '0;
      acc <= '0;
      pcnt <= '0;
    end else begin
      pixel_wr <= 1'b0;
      if (pixel_wr) pixel_addr <= pixel_addr + ADDR_W'(1);
      if (fill) begin
        // stop issuing once the write at the top address is on the bus
        if (!fill_last) begin
          pixel_wr <= 1'b1;
          pixel_dataout <= pcnt != '0 ? acc << (PW - pcnt) : '0;
          pcnt <= '0;
        end
      end else if (bit_valid) begin
        acc <= shifted;
        if (pcnt == PW - CW'(1)) begin
          pixel_wr <= 1'b1;
          pixel_dataout <= shifted;
          pcnt <= '0;
        end else pcnt <= pcnt + CW'(1);
      end
    end
endmodule

// File: rtl/sti_dac_param.sv
// sti_dac_param: parallel-to-serial transmitter feeding a pixel packer with end-of-stream zero fill
module sti_dac_param
  import sti_dac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIX_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              pi_busy,
  output logic              so_data,
  output logic              so_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout,
  output logic              pixel_finish
);
  localparam int BYTE_W = DATA_W / 2;
  localparam int WW = 4 * BYTE_W;
  localparam int CW = $clog2(WW + 1);
  localparam int IW = $clog2(WW);
  state_t state, nxt;
  logic [WW-1:0] word, src, built;
  logic [BYTE_W-1:0] sel_byte;
  logic [CW-1:0] ln, cnt;
  logic [IW-1:0] idx;
  logic msb, wide, accept, fill_last;
  always_comb begin
    sel_byte = pi_low ? pi_data[DATA_W-1:BYTE_W] : pi_data[BYTE_W-1:0];
    wide = pi_length == LEN_3BYTE || pi_length == LEN_4BYTE;
    src = (pi_length == LEN_WORD || wide) ? WW'(pi_data) : WW'(sel_byte);
    // lengths wider than the input word pad with zeros below (fill) or above
    built = !(pi_fill && wide) ? src : pi_length == LEN_4BYTE ? src << DATA_W : src << BYTE_W;
    accept = state == IDLE && load && !pi_end;
    idx = msb ? IW'(ln - cnt - CW'(1)) : IW'(cnt);
    nxt = state == IDLE  ? (pi_end ? FILL : load ? LOAD : IDLE) :
          state == LOAD  ? SHIFT :
          state == SHIFT ? (cnt == ln - CW'(1) ? IDLE : SHIFT) :
          state == FILL  ? (fill_last ? DONE : FILL) : DONE;
    pi_busy = state == LOAD || state == SHIFT;
    so_valid = state == SHIFT;
    so_data = so_valid && word[idx];
    pixel_finish = state == DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      word <= '0;
      ln <= '0;
      cnt <= '0;
      msb <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == SHIFT ? cnt + CW'(1) : '0;
      if (accept) begin
        word <= built;
        ln <= CW'(len_bits(pi_length, BYTE_W));
        msb <= pi_msb;
      end
    end
  sti_pixel_packer #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_packer (
    .clk(clk),
    .reset(reset),
    .bit_valid(so_valid),
    .bit_in(so_data),
    .fill(state == FILL),
    .pixel_wr(pixel_wr),
    .pixel_addr(pixel_addr),
    .pixel_dataout(pixel_dataout),
    .fill_last(fill_last)
  );
endmodule

// File: tb/tb_sti_dac_param.sv
// tb_sti_dac_param: directed vectors for sti_dac_param at default and PIX_W=5/ADDR_W=4 parameters
module tb_sti_dac_param;
  logic clk = 1'b0;
  logic rst0, rst1, load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0] pi_length;
  logic busy0, sd0, sv0, wr0, fin0, busy1, sd1, sv1, wr1, fin1;
  logic [7:0] addr0, dout0;
  logic [3:0] addr1;
  logic [4:0] dout1;
  int cyc = 0, tests = 0, fails = 0;
  logic [31:0] bits;
  int nv, fv, lv, nb, fb, lb;
  logic [15:0] w0[$], w1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sti_dac_param u0 (
    .clk(clk), .reset(rst0), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .pi_busy(busy0), .so_data(sd0), .so_valid(sv0), .pixel_wr(wr0),
    .pixel_addr(addr0), .pixel_dataout(dout0), .pixel_finish(fin0)
  );
  sti_dac_param #(.DATA_W(16), .PIX_W(5), .ADDR_W(4)) u1 (
    .clk(clk), .reset(rst1), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .pi_busy(busy1), .so_data(sd1), .so_valid(sv1), .pixel_wr(wr1),
    .pixel_addr(addr1), .pixel_dataout(dout1), .pixel_finish(fin1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int t0);
    if (sv0) begin
      bits = {bits[30:0], sd0};
      nv++;
      if (fv < 0) fv = cyc - t0;
      lv = cyc - t0;
    end
    if (busy0) begin
      nb++;
      if (fb < 0) fb = cyc - t0;
      lb = cyc - t0;
    end
    if (wr0) w0.push_back({addr0, dout0});
    if (wr1) w1.push_back(16'({addr1, dout1}));
  endtask

  task automatic send(input logic [1:0] len, input logic [15:0] d, input logic f, input logic m,
                      input logic lo, input logic hold, input int n);
    int t0;
    @(negedge clk);
    pi_length = len; pi_data = d; pi_fill = f; pi_msb = m; pi_low = lo; load = 1'b1; t0 = cyc;
    bits = '0; nv = 0; fv = -1; lv = -1; nb = 0; fb = -1; lb = -1;
    w0.delete(); w1.delete();
    repeat (n) begin
      @(negedge clk);
      load = hold && (cyc - t0 <= 17);
      sample(t0);
    end
    load = 1'b0;
  endtask

  initial begin
    int t0, nw, first, last, bad, tfin, extra;
    rst0 = 1; rst1 = 1; load = 0; pi_data = 0; pi_length = 0;
    pi_fill = 0; pi_msb = 0; pi_low = 0; pi_end = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy0, sd0, sv0, wr0, addr0, dout0, fin0}, 64'd0);
    rst0 = 0;

    send(2'b01, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 24);
    check("t1_serial", bits[15:0], 16'hA5C3);
    check("t1_nvalid", nv, 16);
    check("t1_first_valid", fv, 2);
    check("t1_last_valid", lv, 17);
    check("t1_busy_span", {fb[7:0], lb[7:0]}, {8'd1, 8'd17});
    check("t1_nwrites", w0.size(), 2);
    check("t1_wr0", w0[0], {8'd0, 8'hA5});
    check("t1_wr1", w0[1], {8'd1, 8'hC3});

    send(2'b00, 16'h8E21, 1'b0, 1'b0, 1'b1, 1'b0, 16);
    check("t2_serial", bits[7:0], 8'h71);
    check("t2_nvalid", nv, 8);
    check("t2_wr", w0[0], {8'd2, 8'h71});

    send(2'b10, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 32);
    check("t3a_nwrites", w0.size(), 3);
    check("t3a_wrs", {w0[0], w0[1], w0[2]}, {8'd3, 8'h00, 8'd4, 8'h12, 8'd5, 8'h34});
    send(2'b10, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 32);
    check("t3b_wrs", {w0[0], w0[1], w0[2]}, {8'd6, 8'h12, 8'd7, 8'h34, 8'd8, 8'h00});

    send(2'b01, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b1, 24);
    check("t4_nvalid", nv, 16);
    check("t4_valid_span", {fv[7:0], lv[7:0]}, {8'd2, 8'd17});
    check("t4_busy", {nb[7:0], fb[7:0], lb[7:0]}, {8'd17, 8'd1, 8'd17});
    check("t4_serial", bits[15:0], 16'hA5C3);
    check("t4_wrs", {w0.size() == 2, w0[0], w0[1]}, {1'b1, 8'd9, 8'hA5, 8'd10, 8'hC3});

    @(negedge clk); rst0 = 1;
    @(negedge clk); rst0 = 0;
    check("t5_reset_addr", {addr0, wr0, fin0}, 10'd0);
    send(2'b10, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 32);
    check("t5_pre_wrs", {w0[0], w0[1], w0[2]}, {8'd0, 8'h00, 8'd1, 8'h12, 8'd2, 8'h34});
    @(negedge clk); pi_end = 1; t0 = cyc;
    nw = 0; first = -1; last = -1; bad = 0; tfin = -1;
    repeat (300) begin
      @(negedge clk); pi_end = 0;
      if (wr0) begin
        if (first < 0) first = cyc - t0;
        last = cyc - t0;
        if (dout0 != 0 || int'(addr0) != 3 + nw) bad++;
        nw++;
      end
      if (fin0 && tfin < 0) tfin = cyc - t0;
    end
    check("t5_fill_count", nw, 253);
    check("t5_fill_span", {first[15:0], last[15:0]}, {16'd2, 16'd254});
    check("t5_fill_bad", bad, 0);
    check("t5_finish_cycle", tfin, 255);
    load = 1; pi_end = 1; extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (sv0 || wr0 || busy0 || !fin0) extra++;
    end
    load = 0; pi_end = 0;
    check("t5_done_ignores", extra, 0);

    @(negedge clk); rst1 = 0;
    send(2'b11, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 40);
    check("t6_nwrites", w1.size(), 6);
    check("t6_wrs_a", {w1[0], w1[1], w1[2]}, {16'({4'd0, 5'h00}), 16'({4'd1, 5'h00}), 16'({4'd2, 5'h00})});
    check("t6_wrs_b", {w1[3], w1[4], w1[5]}, {16'({4'd3, 5'h0B}), 16'({4'd4, 5'h1D}), 16'({4'd5, 5'h1B})});
    @(negedge clk); pi_end = 1; t0 = cyc; w1.delete();
    repeat (20) begin
      @(negedge clk); pi_end = 0;
      sample(t0);
    end
    check("t6_fill_count", w1.size(), 10);
    check("t6_flush", w1[0], 16'({4'd6, 5'h18}));
    check("t6_fill_last", w1[9], 16'({4'd15, 5'h00}));
    check("t6_finish", fin1, 1'b1);

    @(negedge clk); rst1 = 1;
    @(negedge clk); rst1 = 0;
    @(negedge clk);
    pi_length = 2'b11; pi_data = 16'hFFFF; pi_fill = 0; pi_msb = 0; load = 1; t0 = cyc; w1.delete();
    repeat (11) begin
      @(negedge clk); load = 0;
      sample(t0);
      if (cyc - t0 == 10) begin
        check("t6_midshift_valid", {sv1, busy1}, 2'b11);
        check("t6_midshift_wr", w1.size() == 1 ? w1[0] : 16'hFFFF, 16'({4'd0, 5'h1F}));
        rst1 = 1;
      end
    end
    check("t6_reset_outputs", {busy1, sd1, sv1, wr1, addr1, dout1, fin1}, 64'd0);
    rst1 = 0;
    @(negedge clk); pi_end = 1; t0 = cyc; w1.delete();
    repeat (22) begin
      @(negedge clk); pi_end = 0;
      sample(t0);
    end
    check("t6_no_partial_flush", {w1.size() == 16, w1[0]}, {1'b1, 16'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
